// File: rtl/mioc_pat_seq_if.sv
// rtl/mioc_pat_seq_if.sv - pattern word stream between pattern source and sequencer
interface mioc_pat_seq_if;
   logic       pat_valid;
   logic       pat_ready;
   logic [3:0] pat_data;
   logic       pat_exp;
   logic       pat_last;

   modport master (
      output pat_valid,
      output pat_data,
      output pat_exp,
      output pat_last,
      input  pat_ready
   );

   modport slave (
      input  pat_valid,
      input  pat_data,
      input  pat_exp,
      input  pat_last,
      output pat_ready
   );
endinterface

// File: rtl/mioc_pat_seq.sv
// rtl/mioc_pat_seq.sv - gate-test pattern sequencer; MIOC_SYNC_Z_EN adds a two-flop z synchronizer
module mioc_pat_seq #(
   parameter int SETTLE = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   mioc_pat_seq_if.slave    pat,
   output logic             in1,
   output logic             in2,
   output logic             in3,
   output logic             in4,
   input  logic             z,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] vec_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

`ifdef MIOC_SYNC_Z_EN
   // The synchronizer delays z by two edges, so settling is stretched to match.
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   // Cycles spent in SETTLE after the transfer edge; SAMPLE's edge is then T+SETTLE(+sync).
   localparam int         LOAD   = SETTLE - 1 + SYNC_LAT;
   localparam logic [4:0] LOAD_V = 5'(LOAD);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [3:0]       in_q, in_d;
   logic             exp_q, exp_d;
   logic             last_q, last_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic             pat_ready_q, pat_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             z_smp;

`ifdef MIOC_SYNC_Z_EN
   logic z_s1_q, z_s1_d;
   logic z_s2_q, z_s2_d;

   // Synchronizer next values: shift z through two stages.
   always_comb begin
      z_s1_d = z;
      z_s2_d = z_s1_q;
   end

   // Synchronizer flops, cleared by reset so a fresh run never sees stale z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_s1_q <= 1'b0;
         z_s2_q <= 1'b0;
      end else begin
         z_s1_q <= z_s1_d;
         z_s2_q <= z_s2_d;
      end
   end

   assign z_smp = z_s2_q;
`else
   assign z_smp = z;
`endif

   // Next-state and datapath: fetch a word, apply it, wait, sample z, score it.
   always_comb begin
      state_d = state_q;
      in_d    = in_q;
      exp_d   = exp_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      vec_d   = vec_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = '0;
               vec_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (pat.pat_valid && pat_ready_q) begin
               in_d    = pat.pat_data;
               exp_d   = pat.pat_exp;
               last_d  = pat.pat_last;
               cnt_d   = LOAD_V;
               // With no settle cycles to wait, the very next edge is the sample edge.
               state_d = (LOAD_V == 5'd0) ? S_SAMPLE : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q <= 5'd1) begin
               cnt_d   = 5'd0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_SAMPLE: begin
            vec_d = (vec_q == CNT_MAX) ? vec_q : vec_q + CNT_ONE;
            if (z_smp != exp_q) begin
               err_d = (err_q == CNT_MAX) ? err_q : err_q + CNT_ONE;
            end
            state_d = last_q ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake and status outputs are registered from the upcoming state.
      pat_ready_d = (state_d == S_FETCH);
      busy_d      = (state_d == S_FETCH) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      done_d      = (state_d == S_DONE);
   end

   // Sequencer state and registered outputs; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_q        <= 4'd0;
         exp_q       <= 1'b0;
         last_q      <= 1'b0;
         cnt_q       <= 5'd0;
         err_q       <= '0;
         vec_q       <= '0;
         pat_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_q        <= in_d;
         exp_q       <= exp_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         vec_q       <= vec_d;
         pat_ready_q <= pat_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pat.pat_ready = pat_ready_q;
   assign in1           = in_q[0];
   assign in2           = in_q[1];
   assign in3           = in_q[2];
   assign in4           = in_q[3];
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_cnt       = err_q;
   assign vec_cnt       = vec_q;

endmodule

// File: tb/tb_mioc_pat_seq.sv
// tb/tb_mioc_pat_seq.sv - scoreboard bench for mioc_pat_seq with a slow-settling gate model
`timescale 1ns/1ps
module tb_mioc_pat_seq;
   localparam int SETTLE = 4;
   localparam int CNT_W  = 8;
`ifdef MIOC_SYNC_Z_EN
   localparam int S_LAT = SETTLE + 2;
`else
   localparam int S_LAT = SETTLE;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             z = 1'b0;
   logic             in1, in2, in3, in4, busy, done;
   logic [CNT_W-1:0] err_cnt, vec_cnt;

   mioc_pat_seq_if pif();

   mioc_pat_seq #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .pat     (pif),
      .in1     (in1),
      .in2     (in2),
      .in3     (in3),
      .in4     (in4),
      .z       (z),
      .busy    (busy),
      .done    (done),
      .err_cnt (err_cnt),
      .vec_cnt (vec_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         err;
      int         vec;
      logic [3:0] last;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] pd[$];
   logic       pe[$];
   logic [15:0] tt = 16'h0;
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         t_xfer = -1000;
   int         xfer_cnt = 0;
   int         prev_vec = 0;
   logic       cur_tt = 1'b0;
   logic       done_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [3:0] ins();
      return {in4, in3, in2, in1};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Gate model: z shows the true response only when captured at the edge SETTLE
   // cycles after the word was applied, and the wrong value at every other edge.
   always @(negedge clk) begin
      if (int'(vec_cnt) == prev_vec + 1)
         check("sample_edge", cyc, t_xfer + S_LAT);
      prev_vec = int'(vec_cnt);
      if (pif.pat_valid && pif.pat_ready) begin
         t_xfer = cyc + 1;
         xfer_cnt++;
         cur_tt = tt[pif.pat_data];
      end
      z = ((cyc + 1) == t_xfer + SETTLE) ? cur_tt : ~cur_tt;
   end

   // Monitor: every done pulse is scored against the oldest expected run result.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (done_prev) begin
            checks++; errors++;
            $display("FAIL done_one_pulse: got done high 2 cycles want 1");
         end else if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done want none");
         end else begin
            e = sb.pop_front();
            check("err_cnt", err_cnt, e.err);
            check("vec_cnt", vec_cnt, e.vec);
            check("ins_at_done", ins(), e.last);
            check("busy_at_done", busy, 0);
         end
      end
      done_prev = done;
   end

   task automatic set_word(input int i);
      pif.pat_valid = 1'b1;
      pif.pat_data  = pd[i];
      pif.pat_exp   = pe[i];
      pif.pat_last  = (i == pd.size() - 1);
   endtask

   task automatic run(input int stall_idx, input int poke_idx, input int abort_idx);
      int n, mism, base, k, v0;
      exp_t e;
      logic [3:0] hold;
      n = pd.size();
      mism = 0;
      for (int i = 0; i < n; i++) if (tt[pd[i]] != pe[i]) mism++;
      e.err  = (mism > 255) ? 255 : mism;
      e.vec  = (n > 255) ? 255 : n;
      e.last = pd[n-1];
      if (abort_idx < 0) sb.push_back(e);
      @(posedge clk); #1;
      base = xfer_cnt;
      start = 1'b1;
      set_word(0);
      @(posedge clk); #1;
      start = 1'b0;
      check("ready_after_start", pif.pat_ready, 1);
      for (int i = 0; i < n; i++) begin
         if (i == stall_idx) begin
            pif.pat_valid = 1'b0;
            k = 0;
            while (!pif.pat_ready && k < 50) begin @(posedge clk); #1; k++; end
            hold = ins();
            v0 = int'(vec_cnt);
            repeat (20) begin
               @(posedge clk); #1;
               check("stall_ready", pif.pat_ready, 1);
               check("stall_ins", ins(), hold);
               check("stall_vec", vec_cnt, v0);
            end
         end
         set_word(i);
         k = 0;
         while (xfer_cnt != base + i + 1 && k < 100) begin @(posedge clk); #1; k++; end
         if (k >= 100) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: got %0d transfers want %0d", xfer_cnt - base, i + 1);
            return;
         end
         if (i == poke_idx) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         if (i == abort_idx) begin
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b0;
            pif.pat_valid = 1'b0;
            #1;
            check("abort_outs", {ins(), pif.pat_ready, busy, done}, 0);
            check("abort_err", err_cnt, 0);
            check("abort_vec", vec_cnt, 0);
            repeat (3) @(posedge clk);
            #1;
            check("abort_hold", {ins(), pif.pat_ready, busy, done, err_cnt, vec_cnt}, 0);
            rst_n = 1'b1;
            return;
         end
         if (i + 1 < n) set_word(i + 1);
      end
      // Junk word after the last one must not be consumed outside FETCH.
      pif.pat_valid = 1'b1;
      pif.pat_data  = 4'($urandom);
      pif.pat_exp   = 1'($urandom);
      pif.pat_last  = 1'($urandom);
      k = 0;
      while (sb.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
      if (k >= 100) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done want done");
         sb.delete();
         return;
      end
      repeat (3) @(posedge clk);
      #1;
      check("hold_err", err_cnt, e.err);
      check("hold_vec", vec_cnt, e.vec);
      check("hold_ins", ins(), e.last);
      check("idle_busy", busy, 0);
      pif.pat_valid = 1'b0;
   endtask

   task automatic set_inverter();
      for (int i = 0; i < 16; i++) tt[i] = ~i[0];
   endtask

   initial begin
      int n;
      pif.pat_valid = 1'b0;
      pif.pat_data  = 4'd0;
      pif.pat_exp   = 1'b0;
      pif.pat_last  = 1'b0;
      #12;
      check("rst_ins", ins(), 0);
      check("rst_ctl", {pif.pat_ready, busy, done}, 0);
      check("rst_err", err_cnt, 0);
      check("rst_vec", vec_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Inverter, matching expectations.
      set_inverter();
      pd = '{4'b0000, 4'b0001}; pe = '{1'b1, 1'b0};
      run(-1, -1, -1);
      check("inv_in1_after_done", in1, 1);

      // Inverter, every expectation inverted.
      pd = '{4'b0000, 4'b0001}; pe = '{1'b0, 1'b1};
      run(-1, -1, -1);

      // Stall in FETCH, then resume.
      pd = '{4'd3, 4'd5, 4'd6}; pe = '{1'b0, 1'b1, 1'b1};
      run(1, -1, -1);

      // Random runs with a random gate and a start pulse while busy.
      for (int r = 0; r < 10; r++) begin
         tt = 16'($urandom);
         n = $urandom_range(1, 12);
         pd.delete(); pe.delete();
         for (int i = 0; i < n; i++) begin
            pd.push_back(4'($urandom));
            pe.push_back(1'($urandom));
         end
         run(-1, $urandom_range(0, n - 1), -1);
      end

      // Reset during SETTLE of pattern 2, then a clean run from zero.
      set_inverter();
      pd = '{4'd1, 4'd2, 4'd4}; pe = '{1'b1, 1'b1, 1'b1};
      run(-1, -1, 1);
      pd = '{4'd7, 4'd8, 4'd9, 4'd10}; pe = '{1'b1, 1'b1, 1'b1, 1'b0};
      run(-1, -1, -1);

      // 300 mismatching patterns saturate both counters.
      pd.delete(); pe.delete();
      for (int i = 0; i < 300; i++) begin
         pd.push_back(4'($urandom));
         pe.push_back(~tt[pd[i]]);
      end
      run(-1, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mioc_pat_seq.md
MIOC_PAT_SEQ -- requirements
Module: mioc_pat_seq

Interface
REQ-001 Parameter SETTLE, default 4: clock cycles from pattern apply to sampling z; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of err_cnt and vec_cnt.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins a run.
REQ-006 pat_valid  input  1  pattern word available.
REQ-007 pat_ready  output  1  sequencer accepts pattern word.
REQ-008 pat_data  input  4  bit0..bit3 map to in1..in4.
REQ-009 pat_exp  input  1  expected z for this pattern.
REQ-010 pat_last  input  1  final pattern of the run.
REQ-011 in1, in2, in3, in4  output  1 each  drive the gate-under-test inputs.
REQ-012 z  input  1  gate-under-test output.
REQ-013 busy  output  1  high from start acceptance until done.
REQ-014 done  output  1  one-cycle pulse at end of run.
REQ-015 err_cnt  output  CNT_W  mismatching samples this run.
REQ-016 vec_cnt  output  CNT_W  patterns sampled this run.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, SETTLE, SAMPLE, DONE.
REQ-018 IDLE: pat_ready=0, busy=0; start=1 -> clear err_cnt, vec_cnt to 0, go FETCH.
REQ-019 FETCH: pat_ready=1, busy=1; transfer when pat_valid&pat_ready at an edge; in1..in4 take pat_data at that same edge; pat_exp, pat_last latched; settle counter loaded; go SETTLE.
REQ-020 FETCH with pat_valid=0 SHALL wait indefinitely, in1..in4 holding prior values.
REQ-021 SETTLE: pat_ready=0; count SETTLE-1 cycles, then SAMPLE, so z is sampled at edge T+SETTLE, T = transfer edge (without sync, REQ-033).
REQ-022 SAMPLE (one cycle): vec_cnt+1; if sampled z != latched exp, err_cnt+1; both counters saturate at all-ones, no wrap.
REQ-023 SAMPLE exit: latched last=1 -> DONE, else -> FETCH.
REQ-024 DONE (one cycle): done=1, busy=0 in that cycle; -> IDLE.
REQ-025 in1..in4 SHALL hold the last applied pattern after DONE until next transfer or reset.
REQ-026 err_cnt, vec_cnt SHALL hold final values after DONE until next accepted start.
REQ-027 start when not IDLE SHALL be ignored; no restart, no counter clear.
REQ-028 pat_valid outside FETCH SHALL be ignored; no word consumed.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and all outputs to 0: in1..in4, pat_ready, busy, done, err_cnt, vec_cnt.
REQ-030 Reset mid-run SHALL abort the run; no done pulse; sync flops and settle counter cleared.
REQ-031 First start accepted at first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro MIOC_SYNC_Z_EN selects z input synchronizer.
REQ-033 Defined: z passes through a two-flop synchronizer (reset 0); sample edge becomes T+SETTLE+2, SETTLE state lengthened by 2 cycles.
REQ-034 Undefined: z sampled directly at T+SETTLE; no synchronizer flops.

Verification
REQ-035 Inverter model, SETTLE=4: patterns 0000/exp1, 0001/exp0 (last) -> vec_cnt=2, err_cnt=0, done one pulse, in1=1 after done.
REQ-036 Same stream with exp inverted (0000/exp0, 0001/exp1) -> err_cnt=2, vec_cnt=2.
REQ-037 pat_valid held 0 for 20 cycles in FETCH -> pat_ready stays 1, in1..in4 unchanged, no sample; resume -> normal completion.
REQ-038 300 patterns, all mismatching, CNT_W=8 -> err_cnt=255, vec_cnt=255 (saturated).
REQ-039 rst_n low during SETTLE of pattern 2 -> all outputs 0 asynchronously, no done; new start -> counters from 0.
REQ-040 With MIOC_SYNC_Z_EN: transfer at edge T -> sample at T+6 (SETTLE=4); without: T+4; start pulsed while busy -> ignored.
